// File: rtl/bin2bcd_seq_pkg.sv
// Shared sizing and encoding definitions for the sequential binary-to-BCD converter.
package bin2bcd_seq_pkg;

    // Converter control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Width of the constant used to hold 10**DECLEN for the overflow compare.
    localparam int POW_W = 128;

    // Ceiling log2, used to size the digit-count port and the bit counter.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    // 10**n as a wide constant; the converter compares magnitudes against it.
    function automatic logic [POW_W-1:0] pow10(input int n);
        logic [POW_W-1:0] result;
        result = POW_W'(1);
        for (int i = 0; i < n; i++) begin
            result = (result << 3) + (result << 1);
        end
        return result;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One double-dabble correction cell: a BCD digit above 4 gets 3 added so the
// following left shift carries correctly into the next decade.
module bcd_digit_adj (
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    assign adjusted = (digit > 4'd4) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter: one double-dabble step per clock, BINLEN
// steps per conversion, valid/ready handshakes on both sides. Results wrap
// modulo 10**DECLEN, with ovf flagging the wrap.
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int BINLEN = 30,
    parameter int DECLEN = 9,
    parameter int SIGNED = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BINLEN-1:0]             BIN,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DECLEN*4-1:0]           BCD,
    output logic                          NEG,
    output logic [clog2(DECLEN+1)-1:0]    NDIG,
    output logic                          ovf
);

    localparam int DW     = DECLEN * 4;
    localparam int NDIG_W = clog2(DECLEN + 1);
    localparam int CNT_W  = clog2(BINLEN);
    localparam logic [POW_W-1:0] OVF_BOUND = pow10(DECLEN);

    state_t              state;
    logic [BINLEN-1:0]   mag;
    logic [CNT_W-1:0]    cnt;
    logic [DW-1:0]       adjusted;
    logic [DW-1:0]       shifted;
    logic                unused_carry;
    logic [BINLEN-1:0]   mag_in;
    logic                neg_in;
    logic                ovf_in;
    logic                accept;
    logic [NDIG_W-1:0]   ndig_next;

    // A single bank of digit correctors is reused on every shift cycle.
    for (genvar i = 0; i < DECLEN; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit    (BCD[4*i +: 4]),
            .adjusted (adjusted[4*i +: 4])
        );
    end

    // Shift the corrected digits left, pulling in the next magnitude bit; the
    // bit leaving the top digit is the 10**DECLEN carry and is dropped.
    assign {unused_carry, shifted} = {adjusted, mag[BINLEN-1]};

    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    // Sign and magnitude of the incoming value; the most negative input
    // negates to 2**(BINLEN-1), which still fits in BINLEN unsigned bits.
    assign neg_in = (SIGNED != 0) && BIN[BINLEN-1];
    assign mag_in = neg_in ? ({BINLEN{1'b0}} - BIN) : BIN;
    assign ovf_in = POW_W'(mag_in) >= OVF_BOUND;

    // Significant digit count of the value the final shift will produce.
    always_comb begin
        // NOTE: ndig_next gets a default before the loop so every path assigns it and no latch is inferred.
        ndig_next = NDIG_W'(1);
        for (int i = 1; i < DECLEN; i++) begin
            if (shifted[4*i +: 4] != 4'd0) begin
                ndig_next = NDIG_W'(i + 1);
            end
        end
    end

    // Control FSM with the shift register, counter and registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register here updates from pre-edge values.
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            BCD       <= '0;
            NEG       <= 1'b0;
            NDIG      <= '0;
            ovf       <= 1'b0;
            cnt       <= '0;
            mag       <= '0;
        end else if (accept) begin
            state     <= SHIFT;
            out_valid <= 1'b0;
            BCD       <= '0;
            NEG       <= neg_in;
            NDIG      <= '0;
            ovf       <= ovf_in;
            cnt       <= '0;
            mag       <= mag_in;
        end else begin
            case (state)
                SHIFT: begin
                    BCD <= shifted;
                    mag <= {mag[BINLEN-2:0], 1'b0};
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(BINLEN - 1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        NDIG      <= ndig_next;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
